// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and execute units.
// EXU has priority; IFU anti-starvation; EXU lock for read-modify-write.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int STARVE_MAX = 3,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rvalid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  exu_req,
    input  logic                  exu_we,
    input  logic [ADDR_WIDTH-1:0] exu_addr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    input  logic                  exu_lock,
    output logic                  exu_gnt,
    output logic                  exu_rvalid,
    output logic [DATA_WIDTH-1:0] exu_rdata,
    output logic                  lock_err,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] state;
    logic [3:0] starve_cnt;
    logic [7:0] lock_cnt;
    logic       ifu_rd_q;
    logic       exu_rd_q;
    logic       starved;
    logic       timeout;

    assign starved = (starve_cnt == 4'(STARVE_MAX));
    assign timeout = (state == LOCKED) && exu_lock
                     && (lock_cnt == 8'(LOCK_MAX));

    // Grants are gated by reset so every output shows its reset value
    // for the whole reset cycle, not only after the next edge.
    always_comb begin
        ifu_gnt  = 1'b0;
        exu_gnt  = 1'b0;
        lock_err = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    ifu_gnt = ifu_rd_req && (!exu_req || starved);
                    exu_gnt = exu_req && !ifu_gnt;
                end
                LOCKED: begin
                    exu_gnt  = exu_req && !timeout;
                    lock_err = timeout;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_req  = ifu_gnt || (exu_gnt && !exu_we);
    assign mem_wr_req  = exu_gnt && exu_we;
    assign mem_addr    = ifu_gnt ? ifu_rd_addr
                       : (exu_gnt ? exu_addr : '0);
    assign mem_wr_data = mem_wr_req ? exu_wdata : '0;

    assign ifu_rvalid = ifu_rd_q && !rst;
    assign exu_rvalid = exu_rd_q && !rst;
    assign ifu_rdata  = ifu_rvalid ? mem_rd_data : '0;
    assign exu_rdata  = exu_rvalid ? mem_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            ifu_rd_q   <= 1'b0;
            exu_rd_q   <= 1'b0;
        end else begin
            ifu_rd_q <= ifu_gnt;
            exu_rd_q <= exu_gnt && !exu_we;
            unique case (state)
                IDLE: begin
                    if (ifu_rd_req && !ifu_gnt) begin
                        if (!starved)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else begin
                        starve_cnt <= '0;
                    end
                    if (exu_gnt && exu_lock) begin
                        state    <= LOCKED;
                        lock_cnt <= 8'd1;
                    end
                end
                LOCKED: begin
                    lock_cnt <= lock_cnt + 8'd1;
                    if (!exu_lock || timeout) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [11:0] ifu_rdata;
    logic        exu_req;
    logic        exu_we;
    logic [11:0] exu_addr;
    logic [11:0] exu_wdata;
    logic        exu_lock;
    logic        exu_gnt;
    logic        exu_rvalid;
    logic [11:0] exu_rdata;
    logic        lock_err;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [11:0] mem_addr;
    logic [11:0] mem_wr_data;
    logic [11:0] mem_rd_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ifu_rd_req  (ifu_rd_req),
        .ifu_rd_addr (ifu_rd_addr),
        .ifu_gnt     (ifu_gnt),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rdata   (ifu_rdata),
        .exu_req     (exu_req),
        .exu_we      (exu_we),
        .exu_addr    (exu_addr),
        .exu_wdata   (exu_wdata),
        .exu_lock    (exu_lock),
        .exu_gnt     (exu_gnt),
        .exu_rvalid  (exu_rvalid),
        .exu_rdata   (exu_rdata),
        .lock_err    (lock_err),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [11:0] mem_val(input logic [11:0] a);
        if (a == 12'o0200) return 12'o7402;
        if (a == 12'o0100) return 12'o0017;
        return a ^ 12'o5555;
    endfunction

    always @(posedge clk)
        mem_rd_data <= mem_rd_req ? mem_val(mem_addr) : 12'o0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and let registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        ifu_rd_req  = 1'b0;
        ifu_rd_addr = '0;
        exu_req     = 1'b0;
        exu_we      = 1'b0;
        exu_addr    = '0;
        exu_wdata   = '0;
        exu_lock    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        exu_req = 1'b1;
        #1;
        chk("rst_gnt", {ifu_gnt, exu_gnt}, 2'b00);
        chk("rst_mem", {mem_rd_req, mem_wr_req, mem_addr, mem_wr_data},
            26'd0);
        chk("rst_misc", {ifu_rvalid, exu_rvalid, lock_err}, 3'b000);
        tick();
        rst = 1'b0;
        exu_req = 1'b0;
        tick();

        // IFU-only read
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = 12'o0200;
        #1;
        chk("t1_gnt", {ifu_gnt, exu_gnt}, 2'b10);
        chk("t1_mem", {mem_rd_req, mem_wr_req, mem_addr},
            {2'b10, 12'o0200});
        tick();
        ifu_rd_req = 1'b0;
        #1;
        chk("t1_rvalid", {ifu_rvalid, exu_rvalid}, 2'b10);
        chk("t1_rdata", ifu_rdata, 12'o7402);
        chk("t1_exu_rdata", exu_rdata, 12'o0);

        // EXU write
        tick();
        exu_req   = 1'b1;
        exu_we    = 1'b1;
        exu_addr  = 12'o0050;
        exu_wdata = 12'o1234;
        #1;
        chk("t6_gnt", {ifu_gnt, exu_gnt}, 2'b01);
        chk("t6_mem", {mem_rd_req, mem_wr_req, mem_addr, mem_wr_data},
            {2'b01, 12'o0050, 12'o1234});
        tick();
        idle_inputs();
        #1;
        chk("t6_rvalid", {ifu_rvalid, exu_rvalid}, 2'b00);

        // Continuous contention: E,E,E,I,E,E,E,I
        tick();
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = 12'o0200;
        exu_req     = 1'b1;
        exu_addr    = 12'o0300;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t2_gnt%0d", i), {ifu_gnt, exu_gnt},
                (i % 4 == 3) ? 2'b10 : 2'b01);
            tick();
            #1;
            chk($sformatf("t2_rv%0d", i), {ifu_rvalid, exu_rvalid},
                (i % 4 == 3) ? 2'b10 : 2'b01);
        end
        idle_inputs();
        tick();

        // Read-modify-write under lock with the IFU waiting
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = 12'o0200;
        exu_req     = 1'b1;
        exu_addr    = 12'o0100;
        exu_lock    = 1'b1;
        #1;
        chk("t3_rd_gnt", {ifu_gnt, exu_gnt, mem_rd_req}, 3'b011);
        tick();
        exu_we    = 1'b1;
        exu_wdata = 12'o0020;
        exu_lock  = 1'b0;
        #1;
        chk("t3_rd_data", {exu_rvalid, exu_rdata}, {1'b1, 12'o0017});
        chk("t3_wr_gnt", {ifu_gnt, exu_gnt, mem_wr_req}, 3'b011);
        chk("t3_wr_data", mem_wr_data, 12'o0020);
        tick();
        exu_req = 1'b0;
        exu_we  = 1'b0;
        #1;
        chk("t3_ifu_gnt", {ifu_gnt, exu_gnt}, 2'b10);
        tick();
        idle_inputs();
        tick();

        // Lock timeout after eight locked grants
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = 12'o0200;
        exu_req     = 1'b1;
        exu_addr    = 12'o0300;
        exu_lock    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t4_hold%0d", i), {ifu_gnt, exu_gnt, lock_err},
                3'b010);
            tick();
        end
        #1;
        chk("t4_timeout", {ifu_gnt, exu_gnt, lock_err}, 3'b001);
        tick();
        exu_req  = 1'b0;
        exu_lock = 1'b0;
        #1;
        chk("t4_release", {ifu_gnt, exu_gnt, lock_err}, 3'b100);
        tick();
        idle_inputs();
        tick();

        // Reset in the cycle after an IFU grant
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = 12'o0200;
        #1;
        chk("t5_gnt", ifu_gnt, 1'b1);
        tick();
        rst        = 1'b1;
        ifu_rd_req = 1'b0;
        exu_req    = 1'b1;
        #1;
        chk("t5_rv_rst", {ifu_rvalid, ifu_rdata}, 13'd0);
        chk("t5_gnt_rst", {ifu_gnt, exu_gnt, mem_rd_req}, 3'b000);
        tick();
        rst     = 1'b0;
        exu_req = 1'b0;
        #1;
        chk("t5_rv_after", {ifu_rvalid, exu_rvalid}, 2'b00);
        tick();
        ifu_rd_req = 1'b1;
        #1;
        chk("t5_regnt", {ifu_gnt, mem_addr}, {1'b1, 12'o0200});
        tick();
        ifu_rd_req = 1'b0;
        #1;
        chk("t5_redata", {ifu_rvalid, ifu_rdata}, {1'b1, 12'o7402});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
